// File: rtl/sub_pkg.sv
// Shared constants for the nibble-serial subtractor: slice width and FSM encodings.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sub_pkg;

  localparam int SUB_SLICE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/sub_slice4.sv
// Combinational 4-bit borrow-select slice: sums for cin=0 and cin=1, then selects on cin.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; it has no handshake.
// Ports: a, nb (slice of minuend and inverted subtrahend), cin -> sum, cout.
module sub_slice4
  import sub_pkg::*;
(
  input  logic [SUB_SLICE_W-1:0] a,
  input  logic [SUB_SLICE_W-1:0] nb,
  input  logic                   cin,
  output logic [SUB_SLICE_W-1:0] sum,
  output logic                   cout
);

  logic [SUB_SLICE_W:0] sum0;
  logic [SUB_SLICE_W:0] sum1;

  // Both carry-in cases are formed up front so only a 2:1 mux sits behind cin.
  assign sum0 = {1'b0, a} + {1'b0, nb};
  assign sum1 = {1'b0, a} + {1'b0, nb} + {{SUB_SLICE_W{1'b0}}, 1'b1};

  assign sum  = cin ? sum1[SUB_SLICE_W-1:0] : sum0[SUB_SLICE_W-1:0];
  assign cout = sum0[SUB_SLICE_W] | (sum1[SUB_SLICE_W] & cin);

endmodule

// File: rtl/subtractor_serial.sv
// Nibble-serial WIDTH-bit subtractor (diff = a + ~b + 1) with borrow/zero/ovf and optional compare flags.
// Latency: accept in cycle T -> out_valid in cycle T+NSLICE+1; one operation in flight.
// Backpressure: in_ready only in IDLE; result and flags held stable in DONE until out_ready.
// Ports: clk, rst_n (sync, active-low), flush; in_valid/in_ready with a, b;
//        out_valid/out_ready with diff, borrow, zero, ovf, lt, ltu, eq.
// Build option: define SUB_COMPARE_FLAGS_EN to register lt/ltu/eq; otherwise they are tied to 0.
module subtractor_serial
  import sub_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             zero,
  output logic             ovf,
  output logic             lt,
  output logic             ltu,
  output logic             eq
);

  localparam int NSLICE = WIDTH / SUB_SLICE_W;
  localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

  if ((WIDTH % SUB_SLICE_W) != 0 || WIDTH == 0) begin : g_width_chk
    $error("subtractor_serial: WIDTH must be a non-zero multiple of 4");
  end

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   nb_q, nb_d;
  logic [WIDTH-1:0]   diff_q, diff_d;
  logic               carry_q, carry_d;
  logic               borrow_q, borrow_d;
  logic               zero_q, zero_d;
  logic               ovf_q, ovf_d;

  logic [SUB_SLICE_W-1:0] slice_sum;
  logic                   slice_cout;
  logic                   run_last;

  // Operand registers shift right each RUN cycle, so the active slice is always the low nibble.
  sub_slice4 u_slice (
    .a    (a_q[SUB_SLICE_W-1:0]),
    .nb   (nb_q[SUB_SLICE_W-1:0]),
    .cin  (carry_q),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  assign run_last = !flush && (state_q == ST_RUN) && (idx_q == LAST_IDX);

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    a_d      = a_q;
    nb_d     = nb_q;
    diff_d   = diff_q;
    carry_d  = carry_q;
    borrow_d = borrow_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;

    if (flush) begin
      state_d = ST_IDLE;
      idx_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            state_d = ST_RUN;
            idx_d   = '0;
            a_d     = a;
            nb_d    = ~b;
            carry_d = 1'b1;  // the +1 of two's-complement negation
          end
        end
        ST_RUN: begin
          for (int k = 0; k < NSLICE; k++) begin
            if (idx_q == IDX_W'(k)) begin
              diff_d[k*SUB_SLICE_W +: SUB_SLICE_W] = slice_sum;
            end
          end
          carry_d = slice_cout;
          a_d     = a_q >> SUB_SLICE_W;
          nb_d    = nb_q >> SUB_SLICE_W;
          if (idx_q == LAST_IDX) begin
            state_d  = ST_DONE;
            idx_d    = '0;
            borrow_d = ~slice_cout;
            zero_d   = (diff_d == '0);
            // Operand MSBs sit at the top of the low nibble on the last slice.
            // Operand signs differ exactly when a and ~b share a sign bit.
            ovf_d    = (a_q[SUB_SLICE_W-1] == nb_q[SUB_SLICE_W-1]) &&
                       (diff_d[WIDTH-1] != a_q[SUB_SLICE_W-1]);
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state_d = ST_IDLE;
          end
        end
        default: begin
          state_d = ST_IDLE;
          idx_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      a_q      <= '0;
      nb_q     <= '0;
      diff_q   <= '0;
      carry_q  <= 1'b0;
      borrow_q <= 1'b0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      a_q      <= a_d;
      nb_q     <= nb_d;
      diff_q   <= diff_d;
      carry_q  <= carry_d;
      borrow_q <= borrow_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign diff      = diff_q;
  assign borrow    = borrow_q;
  assign zero      = zero_q;
  assign ovf       = ovf_q;

`ifdef SUB_COMPARE_FLAGS_EN
  logic lt_q, lt_d;
  logic ltu_q, ltu_d;
  logic eq_q, eq_d;

  always_comb begin
    lt_d  = lt_q;
    ltu_d = ltu_q;
    eq_d  = eq_q;
    if (run_last) begin
      lt_d  = ovf_d ^ diff_d[WIDTH-1];  // signed a < b
      ltu_d = borrow_d;
      eq_d  = zero_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lt_q  <= 1'b0;
      ltu_q <= 1'b0;
      eq_q  <= 1'b0;
    end else begin
      lt_q  <= lt_d;
      ltu_q <= ltu_d;
      eq_q  <= eq_d;
    end
  end

  assign lt  = lt_q;
  assign ltu = ltu_q;
  assign eq  = eq_q;
`else
  logic unused_run_last;
  assign unused_run_last = run_last;
  assign lt  = 1'b0;
  assign ltu = 1'b0;
  assign eq  = 1'b0;
`endif

endmodule
